// File: rtl/hilo_div_ctrl_if.sv
// Bundle between the ALU/decoder side and the HI/LO divide controller.
// master: drives instruction/ALU inputs; slave: the controller itself.
interface hilo_div_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              issue;
  logic [3:0]        aluop;
  logic [DATA_W-1:0] res_high;
  logic [DATA_W-1:0] res_low;
  logic              divDone;
  logic              InstDone;
  logic              mfhi;
  logic              mflo;
  logic              mthi;
  logic              mtlo;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              stall;
  logic              busy;
  logic              div_err;

  modport master (
    output issue, aluop,
    output res_high, res_low,
    output divDone, InstDone,
    output mfhi, mflo,
    output mthi, mtlo, wdata,
    input  rdata, hi, lo,
    input  stall, busy, div_err
  );

  modport slave (
    input  issue, aluop,
    input  res_high, res_low,
    input  divDone, InstDone,
    input  mfhi, mflo,
    input  mthi, mtlo, wdata,
    output rdata, hi, lo,
    output stall, busy, div_err
  );
endinterface

// File: rtl/hilo_div_ctrl.sv
// HI/LO register pair with multi-cycle divide capture and stall control.
// Ports: clk, rst (sync, active-high), bus (hilo_div_ctrl_if.slave):
//   in : issue aluop res_high res_low divDone InstDone
//        mfhi mflo mthi mtlo wdata
//   out: rdata hi lo stall busy div_err
module hilo_div_ctrl #(
  parameter int DIV_TIMEOUT = 64,
  parameter int DATA_W      = 32
) (
  input logic             clk,
  input logic             rst,
  hilo_div_ctrl_if.slave  bus
);

  localparam int CW = $clog2(DIV_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV_TIMEOUT);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              err_q, err_d;
  logic              stall_c;
  logic              div_iss;
  logic              mv_op;

  // InstDone only serves as an external consistency check.
  logic unused_inst_done;
  assign unused_inst_done = bus.InstDone;

  assign div_iss = bus.issue & (bus.aluop == 4'h3);
  assign mv_op   = bus.issue &
                   (bus.mfhi | bus.mflo | bus.mthi | bus.mtlo);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = err_q;
    stall_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (div_iss) begin
          if (bus.divDone) begin
            // single-cycle divide: retire at once
            hi_d = bus.res_high;
            lo_d = bus.res_low;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
            stall_c = 1'b1;
          end
        end else if (bus.issue) begin
          if (bus.mthi) hi_d = bus.wdata;
          if (bus.mtlo) lo_d = bus.wdata;
        end
      end
      S_WAIT: begin
        // HI/LO access interlocks until the divide is gone
        stall_c = mv_op;
        if (bus.divDone) begin
          hi_d    = bus.res_high;
          lo_d    = bus.res_low;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q
                                       : cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

  assign bus.stall   = ~rst & stall_c;
  assign bus.busy    = ~rst & (state_q == S_WAIT);
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.div_err = err_q;
  assign bus.rdata   = (bus.issue & bus.mfhi) ? hi_q :
                       (bus.issue & bus.mflo) ? lo_q :
                       '0;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Bench for hilo_div_ctrl: two instances (timeout 64 and 8) share one
// stimulus stream and are compared each cycle against a reference model.
module tb_hilo_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue, divDone, InstDone;
  logic        mfhi, mflo, mthi, mtlo;
  logic [3:0]  aluop;
  logic [31:0] res_high, res_low, wdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hilo_div_ctrl_if #(.DATA_W(32)) if0 ();
  hilo_div_ctrl_if #(.DATA_W(32)) if1 ();

  assign if0.issue    = issue;
  assign if0.aluop    = aluop;
  assign if0.res_high = res_high;
  assign if0.res_low  = res_low;
  assign if0.divDone  = divDone;
  assign if0.InstDone = InstDone;
  assign if0.mfhi     = mfhi;
  assign if0.mflo     = mflo;
  assign if0.mthi     = mthi;
  assign if0.mtlo     = mtlo;
  assign if0.wdata    = wdata;

  assign if1.issue    = issue;
  assign if1.aluop    = aluop;
  assign if1.res_high = res_high;
  assign if1.res_low  = res_low;
  assign if1.divDone  = divDone;
  assign if1.InstDone = InstDone;
  assign if1.mfhi     = mfhi;
  assign if1.mflo     = mflo;
  assign if1.mthi     = mthi;
  assign if1.mtlo     = mtlo;
  assign if1.wdata    = wdata;

  hilo_div_ctrl #(.DIV_TIMEOUT(64), .DATA_W(32)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );
  hilo_div_ctrl #(.DIV_TIMEOUT(8), .DATA_W(32)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );

  // reference model: a divide in flight is "started at cycle m_start"
  int          TO [2] = '{64, 8};
  logic [31:0] m_hi [2] = '{0, 0};
  logic [31:0] m_lo [2] = '{0, 0};
  bit          m_busy [2] = '{0, 0};
  bit          m_err [2] = '{0, 0};
  int          m_start [2] = '{0, 0};
  int          cyc = 0;

  function automatic bit is_mv();
    return issue && (mfhi || mflo || mthi || mtlo);
  endfunction

  function automatic bit is_div();
    return issue && (aluop == 4'h3);
  endfunction

  function automatic bit last_wait(int k);
    return (cyc - m_start[k]) == TO[k] - 1;
  endfunction

  function automatic logic [31:0] exp_v(int k, int f);
    logic [31:0] r;
    r = 0;
    case (f)
      0: if (rst) r = 0;
         else if (m_busy[k])
           r = 32'(is_mv() || (!divDone && !last_wait(k)));
         else r = 32'(is_div() && !divDone);
      1: r = rst ? 0 : 32'(m_busy[k]);
      2: r = !issue ? 0 : mfhi ? m_hi[k] : mflo ? m_lo[k] : 0;
      3: r = m_hi[k];
      4: r = m_lo[k];
      default: r = 32'(m_err[k]);
    endcase
    return r;
  endfunction

  function automatic logic [31:0] act_v(int k, int f);
    logic [31:0] r;
    case (f)
      0: r = 32'(k ? if1.stall : if0.stall);
      1: r = 32'(k ? if1.busy : if0.busy);
      2: r = k ? if1.rdata : if0.rdata;
      3: r = k ? if1.hi : if0.hi;
      4: r = k ? if1.lo : if0.lo;
      default: r = 32'(k ? if1.div_err : if0.div_err);
    endcase
    return r;
  endfunction

  function automatic string fname(int f);
    case (f)
      0: return "stall";
      1: return "busy";
      2: return "rdata";
      3: return "hi";
      4: return "lo";
      default: return "div_err";
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, a, e);
    end
  endtask

  task automatic model_edge(int k);
    if (rst) begin
      m_hi[k] = 0; m_lo[k] = 0;
      m_busy[k] = 0; m_err[k] = 0;
    end else if (m_busy[k]) begin
      if (divDone) begin
        m_hi[k] = res_high; m_lo[k] = res_low;
        m_busy[k] = 0;
      end else if (last_wait(k)) begin
        m_err[k] = 1; m_busy[k] = 0;
      end
    end else if (is_div()) begin
      if (divDone) begin
        m_hi[k] = res_high; m_lo[k] = res_low;
      end else begin
        m_busy[k] = 1; m_start[k] = cyc + 1;
      end
    end else if (issue) begin
      if (mthi) m_hi[k] = wdata;
      if (mtlo) m_lo[k] = wdata;
    end
  endtask

  // sample before the edge: compare both DUTs to the model
  task automatic pre();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int f = 0; f < 6; f++)
        chk($sformatf("m%0d_%s", k, fname(f)),
            act_v(k, f), exp_v(k, f));
      if (!rst && m_busy[k] && !is_mv() && !last_wait(k))
        chk($sformatf("m%0d_instdone", k),
            act_v(k, 0), 32'(!InstDone));
    end
  endtask

  task automatic post();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    cyc++;
    #1;
  endtask

  task automatic set_idle();
    rst = 0; issue = 0; aluop = 0;
    divDone = 0; InstDone = 0;
    mfhi = 0; mflo = 0; mthi = 0; mtlo = 0;
    wdata = 0; res_high = 0; res_low = 0;
  endtask

  task automatic cyc_idle(int n);
    for (int i = 0; i < n; i++) begin
      set_idle(); pre(); post();
    end
  endtask

  task automatic do_reset();
    set_idle(); rst = 1; pre(); post(); rst = 0;
  endtask

  task automatic div_issue();
    set_idle(); issue = 1; aluop = 4'h3;
  endtask

  task automatic div_done(logic [31:0] h, logic [31:0] l);
    divDone = 1; InstDone = 1;
    res_high = h; res_low = l;
  endtask

  typedef struct {
    logic        iss, fh, fl, th, tl;
    logic [31:0] wd;
    logic        e_st;
    logic [31:0] e_rd, e_hi, e_lo;
  } vec_t;

  function automatic vec_t mk(logic iss, logic fh, logic fl,
      logic th, logic tl, logic [31:0] wd, logic [31:0] rd,
      logic [31:0] h, logic [31:0] l);
    vec_t v;
    v.iss = iss; v.fh = fh; v.fl = fl; v.th = th; v.tl = tl;
    v.wd = wd; v.e_st = 0; v.e_rd = rd; v.e_hi = h; v.e_lo = l;
    return v;
  endfunction

  vec_t tbl [9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    tbl[0] = mk(1, 0, 0, 1, 0, 32'h1234, 0, 0, 0);
    tbl[1] = mk(1, 0, 1, 0, 0, 0, 0, 32'h1234, 0);
    tbl[2] = mk(1, 1, 0, 0, 0, 0, 32'h1234, 32'h1234, 0);
    tbl[3] = mk(1, 0, 0, 0, 1, 32'hA5A5, 0, 32'h1234, 0);
    tbl[4] = mk(1, 0, 1, 0, 0, 0, 32'hA5A5, 32'h1234, 32'hA5A5);
    tbl[5] = mk(1, 0, 0, 1, 1, 32'h55, 0, 32'h1234, 32'hA5A5);
    tbl[6] = mk(1, 1, 0, 0, 0, 0, 32'h55, 32'h55, 32'h55);
    tbl[7] = mk(0, 0, 0, 1, 0, 32'h99, 0, 32'h55, 32'h55);
    tbl[8] = mk(1, 0, 1, 0, 0, 0, 32'h55, 32'h55, 32'h55);

    set_idle(); rst = 1;
    @(posedge clk); #1;
    do_reset();

    // move/read table
    for (int i = 0; i < 9; i++) begin
      set_idle();
      issue = tbl[i].iss; mfhi = tbl[i].fh; mflo = tbl[i].fl;
      mthi = tbl[i].th; mtlo = tbl[i].tl; wdata = tbl[i].wd;
      pre();
      chk($sformatf("tbl%0d_stall", i), 32'(if0.stall), 32'(tbl[i].e_st));
      chk($sformatf("tbl%0d_rdata", i), if0.rdata, tbl[i].e_rd);
      chk($sformatf("tbl%0d_hi", i), if0.hi, tbl[i].e_hi);
      chk($sformatf("tbl%0d_lo", i), if0.lo, tbl[i].e_lo);
      post();
    end

    // 33-cycle divide
    do_reset();
    st = 0;
    div_issue(); pre(); st += int'(if0.stall); post();
    for (int i = 1; i < 33; i++) begin
      set_idle(); pre(); st += int'(if0.stall); post();
    end
    set_idle(); div_done(32'h2, 32'h7); pre();
    chk("div33_stall_done", 32'(if0.stall), 0);
    chk("div33_stall_cycles", st, 33);
    post();
    chk("div33_lo", if0.lo, 32'h7);
    chk("div33_hi", if0.hi, 32'h2);
    chk("div33_busy", 32'(if0.busy), 0);

    // HI/LO access while dividing
    do_reset();
    div_issue(); pre(); post();
    for (int i = 1; i < 10; i++) begin
      set_idle(); issue = 1;
      if (i % 3 == 0) begin mthi = 1; wdata = 32'hFFFF_0000; end
      else if (i % 3 == 1) mtlo = 1;
      else mfhi = 1;
      pre();
      chk("hz_stall", 32'(if0.stall), 1);
      post();
    end
    set_idle(); issue = 1; mfhi = 1;
    div_done(32'hDEAD_BEEF, 32'h1); pre();
    chk("hz_stall_done", 32'(if0.stall), 1);
    post();
    set_idle(); issue = 1; mfhi = 1; pre();
    chk("hz_rdata", if0.rdata, 32'hDEAD_BEEF);
    chk("hz_stall_after", 32'(if0.stall), 0);
    post();

    // timeout on the DIV_TIMEOUT=8 instance
    do_reset();
    set_idle(); issue = 1; mthi = 1; wdata = 32'h11; pre(); post();
    set_idle(); issue = 1; mtlo = 1; wdata = 32'h22; pre(); post();
    div_issue(); pre(); post();
    cyc_idle(6);
    set_idle(); pre();
    chk("to_stall_c7", 32'(if1.stall), 1);
    post();
    set_idle(); pre();
    chk("to_stall_c8", 32'(if1.stall), 0);
    chk("to_busy_c8", 32'(if1.busy), 1);
    chk("to_err_c8", 32'(if1.div_err), 0);
    post();
    chk("to_err", 32'(if1.div_err), 1);
    chk("to_busy", 32'(if1.busy), 0);
    chk("to_hi", if1.hi, 32'h11);
    chk("to_lo", if1.lo, 32'h22);
    set_idle(); div_done(32'hDD, 32'hEE); pre(); post();
    chk("to_late_hi", if1.hi, 32'h11);
    chk("to_late_lo", if1.lo, 32'h22);
    cyc_idle(3);
    chk("to_sticky", 32'(if1.div_err), 1);

    // reset in the middle of a divide
    do_reset();
    chk("rst_clears_err", 32'(if1.div_err), 0);
    set_idle(); issue = 1; mthi = 1; wdata = 32'h33; pre(); post();
    div_issue(); pre(); post();
    cyc_idle(4);
    set_idle(); rst = 1; pre();
    chk("rst_stall", 32'(if0.stall), 0);
    chk("rst_busy", 32'(if0.busy), 0);
    post();
    chk("rst_hi", if0.hi, 0);
    chk("rst_busy_after", 32'(if0.busy), 0);
    cyc_idle(1);
    set_idle(); div_done(32'h77, 32'h78); pre();
    chk("rst_late_stall", 32'(if0.stall), 0);
    post();
    chk("rst_late_hi", if0.hi, 0);
    chk("rst_late_lo", if0.lo, 0);
    chk("rst_late_busy", 32'(if0.busy), 0);

    // back-to-back divides and single-cycle completion
    do_reset();
    div_issue(); pre(); post();
    cyc_idle(3);
    set_idle(); div_done(32'hA, 32'hB); pre(); post();
    div_issue(); pre();
    chk("b2b_stall", 32'(if0.stall), 1);
    chk("b2b_busy_pre", 32'(if0.busy), 0);
    post();
    chk("b2b_busy", 32'(if0.busy), 1);
    chk("b2b_hi1", if0.hi, 32'hA);
    cyc_idle(4);
    set_idle(); div_done(32'hC, 32'hD); pre(); post();
    chk("b2b_hi2", if0.hi, 32'hC);
    chk("b2b_lo2", if0.lo, 32'hD);
    div_issue(); div_done(32'hE, 32'hF); pre();
    chk("one_stall", 32'(if0.stall), 0);
    post();
    chk("one_busy", 32'(if0.busy), 0);
    chk("one_hi", if0.hi, 32'hE);
    chk("one_lo", if0.lo, 32'hF);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      set_idle();
      issue = ($urandom_range(0, 3) != 0);
      aluop = ($urandom_range(0, 2) == 0) ? 4'h3
                                          : 4'($urandom_range(0, 15));
      mfhi = ($urandom_range(0, 5) == 0);
      mflo = ($urandom_range(0, 5) == 0);
      mthi = ($urandom_range(0, 5) == 0);
      mtlo = ($urandom_range(0, 5) == 0);
      wdata = $urandom;
      res_high = $urandom;
      res_low = $urandom;
      divDone = ($urandom_range(0, 11) == 0);
      InstDone = divDone;
      rst = ($urandom_range(0, 199) == 0);
      pre(); post();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
